// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared constants for the data-side store buffer
package store_buffer_pkg;

  // Default number of buffered stores.
  localparam int SB_DEPTH = 4;

  // Byte lanes per data word.
  localparam int BYTE_LANES = 4;

  // Word index of a byte address (drops the byte offset).
  function automatic logic [29:0] word_of(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/sb_fwd_merge.sv
// rtl/sb_fwd_merge.sv - per-lane youngest-wins store-to-load forwarding
module sb_fwd_merge
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic [AW-3:0]             ent_addr_i [DEPTH],
  input  logic [BYTE_LANES-1:0]     ent_be_i   [DEPTH],
  input  logic [DW-1:0]             ent_data_i [DEPTH],
  input  logic [DEPTH-1:0]          valid_i,
  input  logic [$clog2(DEPTH)-1:0]  head_i,
  input  logic [BYTE_LANES-1:0]     st_be_i,
  input  logic [AW-3:0]             st_addr_i,
  input  logic [DW-1:0]             st_data_i,
  input  logic [AW-3:0]             ld_addr_i,
  output logic [BYTE_LANES-1:0]     mask_o,
  output logic [DW-1:0]             data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk entries oldest to youngest so later matches overwrite earlier ones;
  // the incoming store is applied last because it is the youngest source.
  always_comb begin
    mask_o = '0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if (valid_i[idx] && (ent_addr_i[idx] == ld_addr_i)) begin
        for (int l = 0; l < BYTE_LANES; l++) begin
          if (ent_be_i[idx][l]) begin
            mask_o[l]        = 1'b1;
            data_o[l*8 +: 8] = ent_data_i[idx][l*8 +: 8];
          end
        end
      end
    end
    if (st_addr_i == ld_addr_i) begin
      for (int l = 0; l < BYTE_LANES; l++) begin
        if (st_be_i[l]) begin
          mask_o[l]        = 1'b1;
          data_o[l*8 +: 8] = st_data_i[l*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store FIFO with RAM drain and load forwarding
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BYTE_LANES-1:0] st_wen_i,
  input  logic [AW-1:0]         st_addr_i,
  input  logic [DW-1:0]         st_wdata_i,
  input  logic                  ld_ren_i,
  input  logic [AW-1:0]         ld_addr_i,
  output logic [DW-1:0]         ld_rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  ovf_o,
  output logic [AW-1:0]         ram_raddr_o,
  output logic                  ram_ren_o,
  input  logic [DW-1:0]         ram_rdata_i,
  output logic                  ram_wreq_o,
  output logic [BYTE_LANES-1:0] ram_wbe_o,
  output logic [AW-1:0]         ram_waddr_o,
  output logic [DW-1:0]         ram_wdata_o,
  input  logic                  ram_wgnt_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int WA = AW - 2;

  logic [WA-1:0]         ent_addr_q [DEPTH];
  logic [BYTE_LANES-1:0] ent_be_q   [DEPTH];
  logic [DW-1:0]         ent_data_q [DEPTH];

  logic [PW-1:0]         head_q, head_d, tail_q, tail_d, off;
  logic [PW:0]           count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [BYTE_LANES-1:0] fwd_mask_q, fwd_mask_d, fwd_mask;
  logic [DW-1:0]         fwd_data_q, fwd_data_d, fwd_data;
  logic [DEPTH-1:0]      valid;
  logic                  st_any, full, pop, push, drop;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^{st_addr_i[1:0], ld_addr_i[1:0]};

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign full_o  = full;
  assign empty_o = (count_q == '0);
  assign ovf_o   = ovf_q;

  assign st_any = |st_wen_i;
  assign pop    = ram_wreq_o & ram_wgnt_i;
  assign push   = st_any & (~full | pop);
  assign drop   = st_any & full & ~pop;

  assign ram_raddr_o = ld_addr_i;
  assign ram_ren_o   = ld_ren_i;
  assign ram_wreq_o  = ~empty_o;
  assign ram_wbe_o   = ram_wreq_o ? ent_be_q[head_q] : '0;
  assign ram_waddr_o = ram_wreq_o ? {ent_addr_q[head_q], 2'b00} : '0;
  assign ram_wdata_o = ram_wreq_o ? ent_data_q[head_q] : '0;

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    valid = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PW'(i) - head_q;
      valid[i] = ({1'b0, off} < count_q);
    end
  end

  sb_fwd_merge #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd (
    .ent_addr_i (ent_addr_q),
    .ent_be_i   (ent_be_q),
    .ent_data_i (ent_data_q),
    .valid_i    (valid),
    .head_i     (head_q),
    .st_be_i    (push ? st_wen_i : '0),
    .st_addr_i  (st_addr_i[AW-1:2]),
    .st_data_i  (st_wdata_i),
    .ld_addr_i  (ld_addr_i[AW-1:2]),
    .mask_o     (fwd_mask),
    .data_o     (fwd_data)
  );

  // Pointer, occupancy, overflow and snapshot next-state.
  always_comb begin
    head_d     = pop  ? head_q + PW'(1) : head_q;
    tail_d     = push ? tail_q + PW'(1) : tail_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    ovf_d      = ovf_q | drop;
    fwd_mask_d = ld_ren_i ? fwd_mask : '0;
    fwd_data_d = ld_ren_i ? fwd_data : fwd_data_q;
  end

  // Control and snapshot registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  // Entry payload is only meaningful while counted, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr_q[tail_q] <= st_addr_i[AW-1:2];
      ent_be_q[tail_q]   <= st_wen_i;
      ent_data_q[tail_q] <= st_wdata_i;
    end
  end

  // Per lane, forwarded bytes override the RAM read data.
  always_comb begin
    ld_rdata_o = ram_rdata_i;
    for (int l = 0; l < BYTE_LANES; l++) begin
      if (fwd_mask_q[l]) ld_rdata_o[l*8 +: 8] = fwd_data_q[l*8 +: 8];
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed scoreboard bench for store_buffer
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  st_wen_i = '0;
  logic [31:0] st_addr_i = '0;
  logic [31:0] st_wdata_i = '0;
  logic        ld_ren_i = 1'b0;
  logic [31:0] ld_addr_i = '0;
  logic [31:0] ld_rdata_o;
  logic        full_o, empty_o, ovf_o;
  logic [31:0] ram_raddr_o;
  logic        ram_ren_o;
  logic [31:0] ram_rdata_i = '0;
  logic        ram_wreq_o;
  logic [3:0]  ram_wbe_o;
  logic [31:0] ram_waddr_o;
  logic [31:0] ram_wdata_o;
  logic        ram_wgnt_i = 1'b0;

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } wr_t;

  wr_t          sb_q[$];
  bit [31:0]    mem [bit [29:0]];
  int           n_pass = 0;
  int           n_total = 0;
  int           wreq_seen = 0;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .st_wen_i    (st_wen_i),
    .st_addr_i   (st_addr_i),
    .st_wdata_i  (st_wdata_i),
    .ld_ren_i    (ld_ren_i),
    .ld_addr_i   (ld_addr_i),
    .ld_rdata_o  (ld_rdata_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .ovf_o       (ovf_o),
    .ram_raddr_o (ram_raddr_o),
    .ram_ren_o   (ram_ren_o),
    .ram_rdata_i (ram_rdata_i),
    .ram_wreq_o  (ram_wreq_o),
    .ram_wbe_o   (ram_wbe_o),
    .ram_waddr_o (ram_waddr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_wgnt_i  (ram_wgnt_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // RAM model (read-before-write) and write-order scoreboard.
  always @(posedge clk) begin
    bit [31:0] w;
    if (ram_wreq_o) wreq_seen++;
    if (ram_ren_o)
      ram_rdata_i <= mem.exists(ram_raddr_o[31:2]) ? mem[ram_raddr_o[31:2]] : 32'h0;
    if (ram_wreq_o && ram_wgnt_i) begin
      if (sb_q.size() == 0) begin
        check("wr_unexpected", ram_waddr_o, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("wr_addr", ram_waddr_o, e.a);
        check("wr_be", {28'h0, ram_wbe_o}, {28'h0, e.be});
        check("wr_data", ram_wdata_o, e.d);
      end
      w = mem.exists(ram_waddr_o[31:2]) ? mem[ram_waddr_o[31:2]] : 32'h0;
      for (int l = 0; l < 4; l++)
        if (ram_wbe_o[l]) w[l*8 +: 8] = ram_wdata_o[l*8 +: 8];
      mem[ram_waddr_o[31:2]] = w;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d, input bit acc);
    wr_t e;
    st_wen_i   = be;
    st_addr_i  = a;
    st_wdata_i = d;
    if (acc) begin
      e.a = {a[31:2], 2'b00};
      e.be = be;
      e.d = d;
      sb_q.push_back(e);
    end
    cycle();
    st_wen_i = '0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_wreq"}, {31'h0, ram_wreq_o}, 32'h0);
    check({pfx, "_wbe"}, {28'h0, ram_wbe_o}, 32'h0);
    check({pfx, "_waddr"}, ram_waddr_o, 32'h0);
    check({pfx, "_wdata"}, ram_wdata_o, 32'h0);
    check({pfx, "_full"}, {31'h0, full_o}, 32'h0);
    check({pfx, "_empty"}, {31'h0, empty_o}, 32'h1);
    check({pfx, "_ovf"}, {31'h0, ovf_o}, 32'h0);
  endtask

  initial begin
    // Reset state
    cycle();
    cycle();
    check_reset_outputs("rst");
    rst = 1'b1;
    cycle();

    // Single word store drains next cycle
    ram_wgnt_i = 1'b1;
    st(32'h100, 4'hF, 32'hDEAD_BEEF, 1'b1);
    check("t1_wreq", {31'h0, ram_wreq_o}, 32'h1);
    check("t1_wbe", {28'h0, ram_wbe_o}, 32'hF);
    check("t1_waddr", ram_waddr_o, 32'h100);
    check("t1_empty_n", {31'h0, empty_o}, 32'h0);
    cycle();
    check("t1_empty", {31'h0, empty_o}, 32'h1);

    // Fill with grant low, overflow on fifth store, then drain in order
    ram_wgnt_i = 1'b0;
    st(32'h400, 4'hF, 32'h0000_0001, 1'b1);
    st(32'h404, 4'h3, 32'h0000_0202, 1'b1);
    st(32'h408, 4'hC, 32'h0303_0000, 1'b1);
    st(32'h40E, 4'h8, 32'h0400_0000, 1'b1);
    check("t2_full", {31'h0, full_o}, 32'h1);
    check("t2_ovf_pre", {31'h0, ovf_o}, 32'h0);
    st(32'h410, 4'hF, 32'h0505_0505, 1'b0);
    check("t2_ovf", {31'h0, ovf_o}, 32'h1);
    check("t2_full_hold", {31'h0, full_o}, 32'h1);
    cycle();
    check("t2_hold_data", ram_wdata_o, 32'h0000_0001);
    check("t2_hold_addr", ram_waddr_o, 32'h400);
    ram_wgnt_i = 1'b1;
    repeat (4) cycle();
    check("t2_empty", {31'h0, empty_o}, 32'h1);
    check("t2_sb_left", sb_q.size(), 32'h0);
    check("t2_ovf_sticky", {31'h0, ovf_o}, 32'h1);

    // Youngest buffered byte wins over older entry and RAM
    ram_wgnt_i = 1'b0;
    mem[30'h80] = 32'h1122_3344;
    st(32'h201, 4'h2, 32'h0000_AA00, 1'b1);
    st(32'h201, 4'h2, 32'h0000_BB00, 1'b1);
    ld_ren_i = 1'b1;
    ld_addr_i = 32'h200;
    cycle();
    ld_ren_i = 1'b0;
    check("t3_fwd", ld_rdata_o, 32'h1122_BB44);
    ram_wgnt_i = 1'b1;
    repeat (2) cycle();
    check("t3_empty", {31'h0, empty_o}, 32'h1);
    ld_ren_i = 1'b1;
    cycle();
    ld_ren_i = 1'b0;
    check("t3_ram_rd", ld_rdata_o, 32'h1122_BB44);

    // Same-cycle incoming store forwards into the load
    ram_wgnt_i = 1'b0;
    ld_ren_i = 1'b1;
    ld_addr_i = 32'h300;
    st(32'h300, 4'hC, 32'h5566_0000, 1'b1);
    ld_ren_i = 1'b0;
    check("t4_fwd_in", ld_rdata_o, 32'h5566_0000);
    cycle();
    check("t4_mask_clr", ld_rdata_o, 32'h0000_0000);
    ram_wgnt_i = 1'b1;
    cycle();
    check("t4_empty", {31'h0, empty_o}, 32'h1);

    // Push while full with grant: accepted, no overflow
    ram_wgnt_i = 1'b0;
    rst = 1'b0;
    cycle();
    check("t5_ovf_rst", {31'h0, ovf_o}, 32'h0);
    rst = 1'b1;
    cycle();
    st(32'h500, 4'hF, 32'hA000_0000, 1'b1);
    st(32'h504, 4'hF, 32'hA000_0001, 1'b1);
    st(32'h508, 4'hF, 32'hA000_0002, 1'b1);
    st(32'h50C, 4'hF, 32'hA000_0003, 1'b1);
    check("t5_full", {31'h0, full_o}, 32'h1);
    ram_wgnt_i = 1'b1;
    st(32'h510, 4'hF, 32'hA000_0004, 1'b1);
    check("t5_still_full", {31'h0, full_o}, 32'h1);
    check("t5_no_ovf", {31'h0, ovf_o}, 32'h0);
    repeat (4) cycle();
    check("t5_empty", {31'h0, empty_o}, 32'h1);
    check("t5_sb_left", sb_q.size(), 32'h0);

    // Reset mid-drain discards pending stores
    ram_wgnt_i = 1'b0;
    st(32'h600, 4'hF, 32'hC000_0000, 1'b0);
    st(32'h604, 4'hF, 32'hC000_0001, 1'b0);
    st(32'h608, 4'hF, 32'hC000_0002, 1'b0);
    check("t6_pending", {31'h0, empty_o}, 32'h0);
    rst = 1'b0;
    #1;
    check_reset_outputs("t6");
    cycle();
    rst = 1'b1;
    wreq_seen = 0;
    ram_wgnt_i = 1'b1;
    repeat (4) cycle();
    check("t6_no_wreq", wreq_seen, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
